// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game controller.
//   state_e    : display-facing game state encodings
//   LfsrSeed   : reset value of the pre-GO delay LFSR
//   LfsrTaps   : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   BcdDigitW  : width of one BCD digit of the reaction time
//   lfsr_step  : one Fibonacci LFSR shift
package reaction_pkg;

  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StWait = 3'b001,
    StFail = 3'b010,
    StGo   = 3'b011,
    StShow = 3'b111
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  localparam int unsigned BcdDigitW = 4;
  localparam int unsigned BcdDigits = 4;
  localparam int unsigned BcdW      = BcdDigitW * BcdDigits;

  // 9999: the largest representable reaction time
  localparam logic [BcdW-1:0] BcdMax = {BcdDigits{4'h9}};

  function automatic logic [15:0] lfsr_step(logic [15:0] s);
    return {s[14:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter for the reaction time.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : synchronous clear to 0000 (has priority)
//   inc_i      : increment by one; ignored once the count is 9999
//   count_o    : registered BCD count, [15:12] most significant
//   sat_o      : count is at 9999
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear_i,
  input  logic            inc_i,
  output logic [BcdW-1:0] count_o,
  output logic            sat_o
);

  logic [BcdW-1:0] count_q, count_d, count_inc;
  logic            carry;

  // Ripple the +1 through the digits; a 9 rolls to 0 and passes the carry on.
  always_comb begin
    count_inc = count_q;
    carry     = 1'b1;
    for (int i = 0; i < BcdDigits; i++) begin
      if (carry) begin
        if (count_q[i*BcdDigitW +: BcdDigitW] == BcdDigitW'(9)) begin
          count_inc[i*BcdDigitW +: BcdDigitW] = '0;
        end else begin
          count_inc[i*BcdDigitW +: BcdDigitW] = count_q[i*BcdDigitW +: BcdDigitW] +
                                                 BcdDigitW'(1);
          carry = 1'b0;
        end
      end
    end
  end

  assign sat_o = (count_q == BcdMax);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !sat_o) begin
      count_d = count_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-time game controller.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   btn      : player button, active-high, asynchronous to clk
//   state    : game state (IDLE 000, WAIT 001, FAIL 010, GO 011, SHOW 111)
//   act_time : reaction time in ms, 4 BCD digits
// Optional build macro BTN_DEBOUNCE_EN: the synchronized button must hold a new level for
// DEBOUNCE_MS consecutive ms ticks before it is accepted.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned MIN_WAIT_MS = 1000,
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  output logic [2:0]  state,
  output logic [15:0] act_time
);

  localparam int unsigned TickDiv = CLK_HZ / 1000;
  localparam int unsigned PrescW  = $clog2(TickDiv);
  localparam int unsigned DlyW    = $clog2(MIN_WAIT_MS + 2048);

  // ---------------------------------------------------------------------------
  // Button synchronizer and press detection
  // ---------------------------------------------------------------------------
  logic       sync1_q, sync2_q;
  logic       btn_lvl, lvl_prev_q;
  logic [1:0] primed_q;
  logic       armed_q;
  logic       press;
  logic       tick;

  // primed_q marks when sync2_q holds a real post-reset sample; armed_q then requires the
  // button to have been seen low, so a button held through reset never counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_prev_q <= 1'b0;
      primed_q   <= '0;
      armed_q    <= 1'b0;
    end else begin
      sync1_q    <= btn;
      sync2_q    <= sync1_q;
      lvl_prev_q <= btn_lvl;
      primed_q   <= {primed_q[0], 1'b1};
      armed_q    <= armed_q | (primed_q[1] & ~sync2_q);
    end
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_MS + 1);

  logic           stable_q;
  logic [DbW-1:0] db_cnt_q;

  // Count ticks while the synchronized level differs from the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      db_cnt_q <= '0;
    end else if (sync2_q == stable_q) begin
      db_cnt_q <= '0;
    end else if (tick) begin
      if (db_cnt_q == DbW'(DEBOUNCE_MS - 1)) begin
        stable_q <= sync2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end
    end
  end

  assign btn_lvl = stable_q;
`else
  logic unused_debounce_ms;
  assign unused_debounce_ms = ^DEBOUNCE_MS;
  assign btn_lvl = sync2_q;
`endif

  assign press = armed_q & btn_lvl & ~lvl_prev_q;

  // ---------------------------------------------------------------------------
  // Game FSM, ms prescaler, delay counter, LFSR
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [DlyW-1:0]     dly_q, dly_d;
  logic [15:0]         lfsr_q;
  logic                cnt_clear, cnt_inc, cnt_sat;

  assign tick = (presc_q == PrescW'(TickDiv - 1));

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    presc_d   = tick ? '0 : presc_q + PrescW'(1);
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      StIdle: begin
        if (press) begin
          state_d = StWait;
          dly_d   = DlyW'(MIN_WAIT_MS) + DlyW'(lfsr_q[10:0]);
          presc_d = '0;
        end
      end
      StWait: begin
        // A press always beats an expiry landing on the same edge.
        if (press) begin
          state_d = StFail;
        end else if (tick) begin
          // <= 1 also covers a zero load when MIN_WAIT_MS is 0.
          if (dly_q <= DlyW'(1)) begin
            state_d   = StGo;
            cnt_clear = 1'b1;
            presc_d   = '0;
          end else begin
            dly_d = dly_q - DlyW'(1);
          end
        end
      end
      StGo: begin
        if (press) begin
          state_d = StShow;
        end else if (tick) begin
          if (cnt_sat) begin
            state_d = StFail;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      StFail, StShow: begin
        if (press) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      presc_q <= '0;
      dly_q   <= '0;
      lfsr_q  <= LfsrSeed;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dly_q   <= dly_d;
      lfsr_q  <= lfsr_step(lfsr_q);
    end
  end

  bcd_counter4 u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .count_o (act_time),
    .sat_o   (cnt_sat)
  );

  assign state = state_q;

endmodule
